// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops are registered at accept, mul runs a 32-step
// shift-add, and clo/clz run an early-terminating leading-bit scan.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  output logic             InReady,
  output logic             Busy,
  input  logic [5:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       Shamt,
  input  logic             RtBit0,
  output logic             OutValid,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             MoveWrite
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned CW = IW + 1;

  localparam logic [5:0] OP_AND  = 6'b000000;
  localparam logic [5:0] OP_OR   = 6'b000001;
  localparam logic [5:0] OP_ADD  = 6'b000010;
  localparam logic [5:0] OP_MUL  = 6'b000011;
  localparam logic [5:0] OP_CLO  = 6'b000100;
  localparam logic [5:0] OP_CLZ  = 6'b000101;
  localparam logic [5:0] OP_SUB  = 6'b000110;
  localparam logic [5:0] OP_SLT  = 6'b000111;
  localparam logic [5:0] OP_SLL  = 6'b001000;
  localparam logic [5:0] OP_SRL  = 6'b001001;
  localparam logic [5:0] OP_MOVZ = 6'b001010;
  localparam logic [5:0] OP_SRA  = 6'b001011;
  localparam logic [5:0] OP_XOR  = 6'b001101;
  localparam logic [5:0] OP_NOR  = 6'b001110;
  localparam logic [5:0] OP_MOVN = 6'b001111;
  localparam logic [5:0] OP_SLLV = 6'b010000;
  localparam logic [5:0] OP_SRLV = 6'b010001;
  localparam logic [5:0] OP_SRAV = 6'b010010;
  localparam logic [5:0] OP_ADDU = 6'b010011;
  localparam logic [5:0] OP_SLTU = 6'b010100;
  localparam logic [5:0] OP_JR   = 6'b100000;
  localparam logic [5:0] OP_BRZ  = 6'b100001;
  localparam logic [5:0] OP_BEQ  = 6'b100010;
  localparam logic [5:0] OP_BNE  = 6'b100011;
  localparam logic [5:0] OP_BLEZ = 6'b100100;
  localparam logic [5:0] OP_BGTZ = 6'b100101;
  localparam logic [5:0] OP_LUI  = 6'b100110;

  typedef enum logic [1:0] {IDLE, MUL, CNT} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [IW-1:0]     iter_q, iter_d, idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              tgt_q, tgt_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              zero_q, zero_d, move_write_q, move_write_d;

  logic [WIDTH-1:0]  sc_res;
  logic              sc_zero, sc_mw;
  logic [WIDTH-1:0]  acc_sum;
  logic              scan_hit;

  assign InReady   = (state_q == IDLE);
  assign Busy      = !InReady;
  assign OutValid  = out_valid_q;
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign MoveWrite = move_write_q;

  // Single-cycle result, branch condition and move enable for the presented code
  always_comb begin
    sc_res  = '0;
    sc_zero = 1'b0;
    sc_mw   = 1'b0;
    case (ALUControl)
      OP_AND:          sc_res = A & B;
      OP_OR:           sc_res = A | B;
      OP_ADD, OP_ADDU: sc_res = A + B;
      OP_SUB:          sc_res = A - B;
      OP_SLT:          sc_res = WIDTH'($signed(A) < $signed(B));
      OP_SLTU:         sc_res = WIDTH'(A < B);
      OP_XOR:          sc_res = A ^ B;
      OP_NOR:          sc_res = ~(A | B);
      OP_SLL:          sc_res = B << Shamt;
      OP_SRL:          sc_res = B >> Shamt;
      OP_SRA:          sc_res = WIDTH'($signed(B) >>> Shamt);
      OP_SLLV:         sc_res = B << A[4:0];
      OP_SRLV:         sc_res = B >> A[4:0];
      OP_SRAV:         sc_res = WIDTH'($signed(B) >>> A[4:0]);
      OP_LUI:          sc_res = {B[15:0], 16'h0000};
      OP_JR:           sc_res = A;
      OP_MOVZ: begin
        sc_res = A;
        sc_mw  = (B == '0);
      end
      OP_MOVN: begin
        sc_res = A;
        sc_mw  = (B != '0);
      end
      OP_BRZ:  sc_zero = RtBit0 ? !A[WIDTH-1] : A[WIDTH-1];
      OP_BEQ:  sc_zero = (A == B);
      OP_BNE:  sc_zero = (A != B);
      OP_BLEZ: sc_zero = A[WIDTH-1] || (A == '0);
      OP_BGTZ: sc_zero = !A[WIDTH-1] && (A != '0);
      default: ;
    endcase
  end

  assign acc_sum  = acc_q + (a_q[iter_q] ? (b_q << iter_q) : '0);
  assign scan_hit = (a_q[idx_q] == tgt_q);

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    iter_d       = iter_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    tgt_d        = tgt_q;
    out_valid_d  = 1'b0;
    result_d     = result_q;
    zero_d       = zero_q;
    move_write_d = move_write_q;
    case (state_q)
      IDLE: begin
        if (InValid) begin
          if (ALUControl == OP_MUL) begin
            state_d = MUL;
            a_d     = A;
            b_d     = B;
            acc_d   = '0;
            iter_d  = '0;
          end else if (ALUControl == OP_CLO || ALUControl == OP_CLZ) begin
            state_d = CNT;
            a_d     = A;
            tgt_d   = (ALUControl == OP_CLO);
            idx_d   = IW'(WIDTH - 1);
            cnt_d   = '0;
          end else begin
            out_valid_d  = 1'b1;
            result_d     = sc_res;
            zero_d       = sc_zero;
            move_write_d = sc_mw;
          end
        end
      end
      MUL: begin
        acc_d  = acc_sum;
        iter_d = iter_q + IW'(1);
        if (iter_q == IW'(WIDTH - 1)) begin
          state_d      = IDLE;
          out_valid_d  = 1'b1;
          result_d     = acc_sum;
          zero_d       = 1'b0;
          move_write_d = 1'b0;
        end
      end
      CNT: begin
        // A match at bit 0 still counts before the scan finishes
        if (scan_hit && idx_q != '0) begin
          cnt_d = cnt_q + CW'(1);
          idx_d = idx_q - IW'(1);
        end else begin
          state_d      = IDLE;
          out_valid_d  = 1'b1;
          result_d     = WIDTH'(cnt_q + CW'(scan_hit));
          zero_d       = 1'b0;
          move_write_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      iter_q       <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      tgt_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      move_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      iter_q       <= iter_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      tgt_q        <= tgt_d;
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      move_write_q <= move_write_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver pushes reference results with the
// expected completion edge, a monitor pops and compares on every OutValid.
module tb_alu_exec_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady, Busy;
  logic [5:0]  ALUControl = '0;
  logic [31:0] A = '0, B = '0;
  logic [4:0]  Shamt = '0;
  logic        RtBit0 = 1'b0;
  logic        OutValid;
  logic [31:0] Result;
  logic        Zero, MoveWrite;

  alu_exec_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady), .Busy(Busy),
    .ALUControl(ALUControl), .A(A), .B(B), .Shamt(Shamt), .RtBit0(RtBit0),
    .OutValid(OutValid), .Result(Result), .Zero(Zero), .MoveWrite(MoveWrite)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        mw;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   next_ok = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Reference model: result, flags and completion delay (edges after accept)
  function automatic void ref_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, input logic rt,
                                 output logic [31:0] r, output logic z, output logic mw,
                                 output int lat);
    int  c;
    bit  run;
    r = 0; z = 0; mw = 0; lat = 0;
    case (op)
      6'd0:        r = a & b;
      6'd1:        r = a | b;
      6'd2, 6'd19: r = a + b;
      6'd3: begin
        r = a * b;
        lat = 32;
      end
      6'd4, 6'd5: begin
        c = 0; run = 1;
        for (int i = 31; i >= 0; i--) begin
          if (run && a[i] == (op == 6'd4)) c++;
          else run = 0;
        end
        r = 32'(c);
        lat = (c == 32) ? 32 : c + 1;
      end
      6'd6:  r = a - b;
      6'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd20: r = (a < b) ? 32'd1 : 32'd0;
      6'd13: r = a ^ b;
      6'd14: r = ~(a | b);
      6'd8:  r = b << sh;
      6'd9:  r = b >> sh;
      6'd11: r = $signed(b) >>> sh;
      6'd16: r = b << a[4:0];
      6'd17: r = b >> a[4:0];
      6'd18: r = $signed(b) >>> a[4:0];
      6'd38: r = {b[15:0], 16'h0000};
      6'd32: r = a;
      6'd10: begin r = a; mw = (b == 0); end
      6'd15: begin r = a; mw = (b != 0); end
      6'd33: z = rt ? ($signed(a) >= 32'sd0) : ($signed(a) < 32'sd0);
      6'd34: z = (a == b);
      6'd35: z = (a != b);
      6'd36: z = ($signed(a) <= 32'sd0);
      6'd37: z = ($signed(a) > 32'sd0);
      default: ;
    endcase
  endfunction

  // Present one op, hold it until accepted, check accept edge, record expectation
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic rt, input bit push);
    exp_t e;
    int   lat, req, n, exp_n, waitc;
    @(negedge Clk);
    ALUControl = op; A = a; B = b; Shamt = sh; RtBit0 = rt; InValid = 1'b1;
    req = cyc + 1;
    waitc = 0;
    while (!InReady && waitc < 100) begin
      @(negedge Clk);
      waitc++;
    end
    checks++;
    if (!InReady) begin
      failures++;
      $display("FAIL accept_timeout op=%b got InReady=0 required 1 within 100 cycles", op);
      InValid = 1'b0;
      return;
    end
    n = cyc + 1;
    exp_n = (req > next_ok) ? req : next_ok;
    if (n != exp_n) begin
      failures++;
      $display("FAIL accept_edge op=%b got %0d required %0d", op, n, exp_n);
    end
    ref_op(op, a, b, sh, rt, e.r, e.z, e.mw, lat);
    e.cyc = n + lat;
    if (push) q.push_back(e);
    next_ok = n + lat + 1;
    @(posedge Clk);
    #1 InValid = 1'b0;
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if ({InReady, Busy, OutValid, Zero, MoveWrite, Result} !== {5'b10000, 32'h0}) begin
      failures++;
      $display("FAIL %s got rdy=%b busy=%b ov=%b z=%b mw=%b res=%h required rdy=1 busy=0 ov=0 z=0 mw=0 res=0",
               name, InReady, Busy, OutValid, Zero, MoveWrite, Result);
    end
  endtask

  // Monitor: every OutValid must match the oldest expectation, on its cycle
  always @(negedge Clk) begin
    if (OutValid) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_outvalid cyc=%0d got res=%h required no output", cyc, Result);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({Result, Zero, MoveWrite} !== {e.r, e.z, e.mw}) begin
          failures++;
          $display("FAIL result cyc=%0d got res=%h z=%b mw=%b required res=%h z=%b mw=%b",
                   cyc, Result, Zero, MoveWrite, e.r, e.z, e.mw);
        end
        checks++;
        if (cyc != e.cyc) begin
          failures++;
          $display("FAIL out_cycle got %0d required %0d", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    logic [5:0]  op;
    logic [31:0] a, b;
    int          waitc;

    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    check_reset_state("reset_state");
    next_ok = 0;

    // Back-to-back single-cycle ops
    issue(6'd2,  32'd7,        32'd9, 5'd0, 1'b0, 1);
    issue(6'd6,  32'd5,        32'd7, 5'd0, 1'b0, 1);
    issue(6'd7,  32'hFFFFFFFF, 32'd1, 5'd0, 1'b0, 1);
    issue(6'd20, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0, 1);
    issue(6'd11, 32'd0, 32'h80000000, 5'd4, 1'b0, 1);

    // mul followed by add queued behind it
    issue(6'd3, 32'h00010003, 32'h00020005, 5'd0, 1'b0, 1);
    issue(6'd2, 32'd1, 32'd2, 5'd0, 1'b0, 1);

    // Bit scans including the full-width and immediate-mismatch cases
    issue(6'd4, 32'hFFFFFFFF, 32'd0, 5'd0, 1'b0, 1);
    issue(6'd5, 32'h00F00000, 32'd0, 5'd0, 1'b0, 1);
    issue(6'd4, 32'h7FFFFFFF, 32'd0, 5'd0, 1'b0, 1);
    issue(6'd5, 32'h80000000, 32'd0, 5'd0, 1'b0, 1);
    issue(6'd5, 32'h00000000, 32'd0, 5'd0, 1'b0, 1);
    issue(6'd13, 32'hA5A5A5A5, 32'h0F0F0F0F, 5'd0, 1'b0, 1);

    // Branches and conditional moves
    issue(6'd34, 32'd3, 32'd3, 5'd0, 1'b0, 1);
    issue(6'd35, 32'd3, 32'd3, 5'd0, 1'b0, 1);
    issue(6'd36, 32'd0, 32'd0, 5'd0, 1'b0, 1);
    issue(6'd37, 32'd0, 32'd0, 5'd0, 1'b0, 1);
    issue(6'd33, 32'hFFFFFFFF, 32'd0, 5'd0, 1'b0, 1);
    issue(6'd33, 32'hFFFFFFFF, 32'd0, 5'd0, 1'b1, 1);
    issue(6'd10, 32'h12345678, 32'd0, 5'd0, 1'b0, 1);
    issue(6'd15, 32'h12345678, 32'd0, 5'd0, 1'b0, 1);
    issue(6'd63, 32'h12345678, 32'd5, 5'd0, 1'b0, 1);

    // Abort a mul with reset; reset also carries a presented op that must be dropped
    issue(6'd3, 32'hFFFF1234, 32'h00ABCDEF, 5'd0, 1'b0, 0);
    repeat (9) @(negedge Clk);
    Rst = 1'b1;
    InValid = 1'b1; ALUControl = 6'd2; A = 32'd1; B = 32'd1;
    @(negedge Clk);
    Rst = 1'b0; InValid = 1'b0;
    check_reset_state("post_abort_state");
    next_ok = 0;
    issue(6'd3, 32'd3, 32'd4, 5'd0, 1'b0, 1);

    // Op held during a scan is taken only once InReady returns
    issue(6'd5, 32'h00F00000, 32'd0, 5'd0, 1'b0, 1);
    issue(6'd0, 32'hFF00FF00, 32'h0FF00FF0, 5'd0, 1'b0, 1);

    // Randomized ops with occasional idle gaps
    for (int k = 0; k < 80; k++) begin
      op = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 3))
        0: a = $urandom >> $urandom_range(0, 31);
        1: a = ~($urandom >> $urandom_range(0, 31));
        2: a = ($urandom_range(0, 1) == 1) ? 32'h0 : 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      issue(op, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge Clk);
    end

    waitc = 0;
    while (q.size() != 0 && waitc < 200) begin
      @(negedge Clk);
      waitc++;
    end
    @(negedge Clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending required 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
